// File: rtl/pixgen_pkg.sv
// Shared encodings for the pattern stream generator: pattern modes, FSM states, colour-bar constants.
// Border forcing is controlled by the PIXGEN_BORDER_EN macro in pattern_pixel.
package pixgen_pkg;

    localparam logic [1:0] MODE_GRADIENT = 2'd0;
    localparam logic [1:0] MODE_BARS     = 2'd1;
    localparam logic [1:0] MODE_CHECKER  = 2'd2;
    localparam logic [1:0] MODE_SOLID    = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    // Bars run white..black left to right: bar k shows colour index 7-k as {r,g,b} bits.
    localparam int         BAR_COUNT       = 8;
    localparam logic [2:0] BAR_FIRST_COLOR = 3'd7;

endpackage

// File: rtl/pattern_pixel.sv
// Combinational pixel colour for one (x, y) position under the selected pattern.
// Define PIXGEN_BORDER_EN to force the outermost rows/columns of the frame to all-ones.
module pattern_pixel
    import pixgen_pkg::*;
#(
    parameter int X_SIZE     = 640,
    parameter int Y_SIZE     = 480,
    parameter int COLOR_W    = 8,
    parameter int CHECK_LOG2 = 5,
    parameter int X_W        = 10,
    parameter int Y_W        = 9
) (
    input  logic [X_W-1:0]       x,
    input  logic [Y_W-1:0]       y,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] color,
    input  logic [COLOR_W-1:0]   frame_off,
    output logic [3*COLOR_W-1:0] pix
);

    localparam int BAR_W = (X_SIZE / BAR_COUNT > 0) ? X_SIZE / BAR_COUNT : 1;
    localparam logic [COLOR_W-1:0] ONES = '1;
    localparam logic [COLOR_W-1:0] ZERO = '0;

    logic [2:0] bar_k;
    logic [2:0] bar_c;

    always_comb begin
        pix   = '0;
        bar_k = (32'(x) / BAR_W > 32'd7) ? 3'd7 : 3'(32'(x) / BAR_W);
        bar_c = BAR_FIRST_COLOR - bar_k;
        case (mode)
            MODE_GRADIENT: pix = {COLOR_W'(32'(x) + 32'(frame_off)),
                                  COLOR_W'(32'(y) + 32'(frame_off)),
                                  COLOR_W'(32'(x) + 32'(y) + 32'(frame_off))};
            MODE_BARS:     pix = {bar_c[2] ? ONES : ZERO,
                                  bar_c[1] ? ONES : ZERO,
                                  bar_c[0] ? ONES : ZERO};
            MODE_CHECKER:  pix = ((((32'(x) ^ 32'(y)) >> CHECK_LOG2) & 32'd1) != 32'd0) ? color : '0;
            default:       pix = color;
        endcase
`ifdef PIXGEN_BORDER_EN
        if (x == '0 || 32'(x) == X_SIZE - 1 || y == '0 || 32'(y) == Y_SIZE - 1) begin
            pix = '1;
        end
`endif
    end

endmodule

// File: rtl/pattern_stream_gen.sv
// Frame-based AXI4-Stream test-pattern source (tuser=SOF, tlast=EOL) with config shadowed at frame start.
// Optional border forcing via PIXGEN_BORDER_EN (see pattern_pixel).
module pattern_stream_gen
    import pixgen_pkg::*;
#(
    parameter int X_SIZE       = 640,
    parameter int Y_SIZE       = 480,
    parameter int PIX_PER_BEAT = 1,
    parameter int COLOR_W      = 8,
    parameter int CHECK_LOG2   = 5
) (
    input  logic                                  out_stream_aclk,
    input  logic                                  periph_reset,
    input  logic                                  cfg_enable,
    input  logic [1:0]                            cfg_mode,
    input  logic [3*COLOR_W-1:0]                  cfg_color,
    output logic [PIX_PER_BEAT*3*COLOR_W-1:0]     out_stream_tdata,
    output logic [PIX_PER_BEAT*3*COLOR_W/8-1:0]   out_stream_tkeep,
    output logic                                  out_stream_tlast,
    output logic                                  out_stream_tuser,
    output logic                                  out_stream_tvalid,
    input  logic                                  out_stream_tready,
    output logic [15:0]                           status_frame_cnt,
    output logic                                  status_busy
);

    localparam int PIX_W   = 3 * COLOR_W;
    localparam int DATA_W  = PIX_PER_BEAT * PIX_W;
    localparam int X_BEATS = X_SIZE / PIX_PER_BEAT;
    localparam int XB_W    = (X_BEATS > 1) ? $clog2(X_BEATS) : 1;
    localparam int X_W     = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int Y_W     = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [XB_W-1:0] XB_LAST = XB_W'(X_BEATS - 1);
    localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(Y_SIZE - 1);

    logic [1:0]         state_q, state_d;
    logic [XB_W-1:0]    x_beat_q, x_beat_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [1:0]         mode_q, mode_d;
    logic [PIX_W-1:0]   color_q, color_d;
    logic [COLOR_W-1:0] frame_off_q, frame_off_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic               tuser_q, tuser_d;
    logic [DATA_W-1:0]  tdata_q, tdata_d;

    logic               accept;
    logic               line_end;
    logic               frame_end;
    logic [XB_W-1:0]    nxt_xb;
    logic [Y_W-1:0]     nxt_y;
    logic [XB_W-1:0]    gen_xb;
    logic [Y_W-1:0]     gen_y;
    logic [1:0]         gen_mode;
    logic [PIX_W-1:0]   gen_color;
    logic [COLOR_W-1:0] gen_off;
    logic [DATA_W-1:0]  gen_data;

    assign accept    = tvalid_q & out_stream_tready;
    assign line_end  = (x_beat_q == XB_LAST);
    assign frame_end = line_end && (y_q == Y_LAST);
    assign nxt_xb    = line_end ? '0 : x_beat_q + 1'b1;
    assign nxt_y     = line_end ? y_q + 1'b1 : y_q;

    // The generator always computes the beat that will be registered next:
    // beat 0 from live config during LOAD, otherwise the successor of the beat on the bus.
    always_comb begin
        if (state_q == ST_LOAD) begin
            gen_xb    = '0;
            gen_y     = '0;
            gen_mode  = cfg_mode;
            gen_color = cfg_color;
            gen_off   = COLOR_W'(frame_cnt_q);
        end else begin
            gen_xb    = nxt_xb;
            gen_y     = nxt_y;
            gen_mode  = mode_q;
            gen_color = color_q;
            gen_off   = frame_off_q;
        end
    end

    for (genvar i = 0; i < PIX_PER_BEAT; i++) begin : g_pix
        logic [X_W-1:0] px;
        assign px = X_W'(32'(gen_xb) * PIX_PER_BEAT + i);

        pattern_pixel #(
            .X_SIZE     (X_SIZE),
            .Y_SIZE     (Y_SIZE),
            .COLOR_W    (COLOR_W),
            .CHECK_LOG2 (CHECK_LOG2),
            .X_W        (X_W),
            .Y_W        (Y_W)
        ) u_pix (
            .x         (px),
            .y         (gen_y),
            .mode      (gen_mode),
            .color     (gen_color),
            .frame_off (gen_off),
            .pix       (gen_data[i*PIX_W +: PIX_W])
        );
    end

    always_comb begin
        state_d     = state_q;
        x_beat_d    = x_beat_q;
        y_d         = y_q;
        mode_d      = mode_q;
        color_d     = color_q;
        frame_off_d = frame_off_q;
        frame_cnt_d = frame_cnt_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tuser_d     = tuser_q;
        tdata_d     = tdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_enable) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                mode_d      = cfg_mode;
                color_d     = cfg_color;
                frame_off_d = COLOR_W'(frame_cnt_q);
                x_beat_d    = '0;
                y_d         = '0;
                tvalid_d    = 1'b1;
                tuser_d     = 1'b1;
                tlast_d     = (X_BEATS == 1);
                tdata_d     = gen_data;
                state_d     = ST_STREAM;
            end
            ST_STREAM: begin
                if (accept) begin
                    if (frame_end) begin
                        tvalid_d    = 1'b0;
                        tlast_d     = 1'b0;
                        tuser_d     = 1'b0;
                        x_beat_d    = '0;
                        y_d         = '0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = cfg_enable ? ST_LOAD : ST_IDLE;
                    end else begin
                        x_beat_d = nxt_xb;
                        y_d      = nxt_y;
                        tdata_d  = gen_data;
                        tuser_d  = 1'b0;
                        tlast_d  = (nxt_xb == XB_LAST);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
        if (periph_reset) begin
            state_q     <= ST_IDLE;
            x_beat_q    <= '0;
            y_q         <= '0;
            mode_q      <= '0;
            color_q     <= '0;
            frame_off_q <= '0;
            frame_cnt_q <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            tdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            x_beat_q    <= x_beat_d;
            y_q         <= y_d;
            mode_q      <= mode_d;
            color_q     <= color_d;
            frame_off_q <= frame_off_d;
            frame_cnt_q <= frame_cnt_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            tdata_q     <= tdata_d;
        end
    end

    assign out_stream_tdata  = tdata_q;
    assign out_stream_tkeep  = '1;
    assign out_stream_tlast  = tlast_q;
    assign out_stream_tuser  = tuser_q;
    assign out_stream_tvalid = tvalid_q;
    assign status_frame_cnt  = frame_cnt_q;
    assign status_busy       = (state_q == ST_LOAD) || (state_q == ST_STREAM);

endmodule

// File: tb/tb_pattern_stream_gen.sv
// Scoreboard bench for pattern_stream_gen at 16x4, 4 pixels per beat, 2-pixel checker squares.
module tb_pattern_stream_gen;

    localparam int X_SIZE = 16;
    localparam int Y_SIZE = 4;
    localparam int PPB    = 4;
    localparam int CW     = 8;
    localparam int CL     = 1;
    localparam int XB     = X_SIZE / PPB;
    localparam int DW     = PPB * 3 * CW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_enable;
    logic [1:0]    cfg_mode;
    logic [23:0]   cfg_color;
    logic [DW-1:0] tdata;
    logic [DW/8-1:0] tkeep;
    logic          tlast, tuser, tvalid, tready;
    logic [15:0]   frame_cnt;
    logic          busy;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } beat_t;

    beat_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    exp_cnt = 0;

    logic          held_v = 1'b0;
    logic [DW-1:0] held_data;
    logic          held_last, held_user;

    pattern_stream_gen #(
        .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE), .PIX_PER_BEAT(PPB), .COLOR_W(CW), .CHECK_LOG2(CL)
    ) dut (
        .out_stream_aclk   (clk),
        .periph_reset      (rst),
        .cfg_enable        (cfg_enable),
        .cfg_mode          (cfg_mode),
        .cfg_color         (cfg_color),
        .out_stream_tdata  (tdata),
        .out_stream_tkeep  (tkeep),
        .out_stream_tlast  (tlast),
        .out_stream_tuser  (tuser),
        .out_stream_tvalid (tvalid),
        .out_stream_tready (tready),
        .status_frame_cnt  (frame_cnt),
        .status_busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] model_pix(int x, int y, int mode, logic [23:0] col, int off);
        int r, g, b, k, c;
`ifdef PIXGEN_BORDER_EN
        if (x == 0 || x == X_SIZE - 1 || y == 0 || y == Y_SIZE - 1) return 24'hFFFFFF;
`endif
        case (mode)
            0: begin
                r = (x + off) % 256;
                g = (y + off) % 256;
                b = (x + y + off) % 256;
                return {r[7:0], g[7:0], b[7:0]};
            end
            1: begin
                k = x / (X_SIZE / 8);
                if (k > 7) k = 7;
                c = 7 - k;
                return {((c & 4) != 0) ? 8'hFF : 8'h00,
                        ((c & 2) != 0) ? 8'hFF : 8'h00,
                        ((c & 1) != 0) ? 8'hFF : 8'h00};
            end
            2: return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? col : 24'h000000;
            default: return col;
        endcase
    endfunction

    task automatic push_frame(input int mode, input logic [23:0] col);
        beat_t   b;
        logic [DW-1:0] d;
        int      off;
        off = exp_cnt % 256;
        for (int y = 0; y < Y_SIZE; y++) begin
            for (int xb = 0; xb < XB; xb++) begin
                d = '0;
                for (int i = 0; i < PPB; i++) d[i*24 +: 24] = model_pix(xb * PPB + i, y, mode, col, off);
                b.data = d;
                b.last = (xb == XB - 1);
                b.user = (xb == 0 && y == 0);
                sb.push_back(b);
            end
        end
        exp_cnt++;
    endtask

    // Output monitor: scoreboard on every accepted beat, AXI hold rule while stalled.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                n_vec++;
                if (tvalid !== 1'b1 || tdata !== held_data || tlast !== held_last || tuser !== held_user) begin
                    n_err++;
                    $display("FAIL hold: got v=%b l=%b u=%b d=%h, required v=1 l=%b u=%b d=%h",
                             tvalid, tlast, tuser, tdata, held_last, held_user, held_data);
                end
            end
            if (tvalid === 1'b1 && tready === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: got d=%h with nothing expected", tdata);
                end else begin
                    e = sb.pop_front();
                    if (tdata !== e.data || tlast !== e.last || tuser !== e.user) begin
                        n_err++;
                        $display("FAIL beat: got d=%h l=%b u=%b, required d=%h l=%b u=%b",
                                 tdata, tlast, tuser, e.data, e.last, e.user);
                    end
                end
            end
            held_v    = (tvalid === 1'b1) && (tready !== 1'b1);
            held_data = tdata;
            held_last = tlast;
            held_user = tuser;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sb(input int n, input int budget, input bit rnd);
        int c = 0;
        while (sb.size() > n && c < budget) begin
            tick();
            if (rnd) tready = 1'($urandom_range(0, 1));
            c++;
        end
        n_vec++;
        if (sb.size() > n) begin
            n_err++;
            $display("FAIL wait_sb: got %0d beats queued after %0d cycles, required <= %0d", sb.size(), budget, n);
        end
    endtask

    task automatic check_idle(input string name, input int cnt);
        n_vec++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'(cnt)) begin
            n_err++;
            $display("FAIL %s: got tvalid=%b busy=%b cnt=%0d, required 0 0 %0d", name, tvalid, busy, frame_cnt, cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_vec++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || tuser !== 1'b0 || tdata !== '0 ||
            frame_cnt !== 16'd0 || busy !== 1'b0 || tkeep !== '1) begin
            n_err++;
            $display("FAIL reset: got v=%b l=%b u=%b d=%h cnt=%0d busy=%b keep=%h",
                     tvalid, tlast, tuser, tdata, frame_cnt, busy, tkeep);
        end
        rst = 1'b0;
        repeat (2) tick();
        check_idle("reset_release", 0);
    endtask

    task automatic test_gradient();
        logic [DW-1:0] exp0;
        int            gaps = 0;
`ifdef PIXGEN_BORDER_EN
        exp0 = '1;
`else
        exp0 = 96'h030003_020002_010001_000000;
`endif
        tready = 1'b1;
        cfg_mode = 2'd0;
        push_frame(0, 24'h0);
        push_frame(0, 24'h0);
        cfg_enable = 1'b1;
        tick();
        n_vec++;
        if (busy !== 1'b1 || tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL load_cycle: got busy=%b tvalid=%b, required 1 0", busy, tvalid);
        end
        tick();
        n_vec++;
        if (tvalid !== 1'b1 || tuser !== 1'b1 || tdata !== exp0) begin
            n_err++;
            $display("FAIL first_beat: got v=%b u=%b d=%h, required 1 1 %h", tvalid, tuser, tdata, exp0);
        end
        for (int i = 1; i < XB * Y_SIZE; i++) begin
            tick();
            if (tvalid !== 1'b1) gaps++;
        end
        n_vec++;
        if (gaps != 0) begin
            n_err++;
            $display("FAIL no_bubble: got %0d idle cycles inside frame, required 0", gaps);
        end
        tick();
        n_vec++;
        if (tvalid !== 1'b0 || frame_cnt !== 16'd1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL frame_gap: got v=%b cnt=%0d busy=%b, required 0 1 1", tvalid, frame_cnt, busy);
        end
        tick();
        n_vec++;
        if (tvalid !== 1'b1 || tuser !== 1'b1) begin
            n_err++;
            $display("FAIL second_sof: got v=%b u=%b, required 1 1", tvalid, tuser);
        end
        cfg_enable = 1'b0;
        wait_sb(0, 200, 1'b0);
        repeat (2) tick();
        check_idle("gradient_end", 2);
    endtask

    task automatic test_random_ready();
        cfg_mode = 2'd1;
        push_frame(1, 24'h0);
        push_frame(1, 24'h0);
        cfg_enable = 1'b1;
        wait_sb(XB * Y_SIZE - 1, 2000, 1'b1);
        cfg_enable = 1'b0;
        cfg_mode = 2'd2;
        wait_sb(0, 2000, 1'b1);
        tready = 1'b1;
        repeat (2) tick();
        check_idle("random_end", 4);
    endtask

    task automatic test_mode_switch();
        cfg_mode  = 2'd2;
        cfg_color = 24'h123456;
        push_frame(2, 24'h123456);
        push_frame(3, 24'h123456);
        cfg_enable = 1'b1;
        wait_sb(24, 200, 1'b0);
        cfg_mode = 2'd3;
        wait_sb(8, 200, 1'b0);
        cfg_mode   = 2'd0;
        cfg_color  = 24'hABCDEF;
        cfg_enable = 1'b0;
        wait_sb(0, 200, 1'b0);
        repeat (2) tick();
        check_idle("mode_switch_end", 6);
    endtask

    task automatic test_reset_midframe();
        cfg_mode = 2'd0;
        push_frame(0, 24'h0);
        cfg_enable = 1'b1;
        wait_sb(10, 200, 1'b0);
        rst = 1'b1;
        #1;
        n_vec++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || tuser !== 1'b0 || tdata !== '0 ||
            frame_cnt !== 16'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got v=%b l=%b u=%b d=%h cnt=%0d busy=%b",
                     tvalid, tlast, tuser, tdata, frame_cnt, busy);
        end
        sb.delete();
        exp_cnt = 0;
        cfg_enable = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check_idle("after_abort", 0);
    endtask

    task automatic test_back_to_back();
        cfg_mode  = 2'd3;
        cfg_color = 24'h00FF80;
        push_frame(3, 24'h00FF80);
        cfg_enable = 1'b1;
        tick();
        cfg_enable = 1'b0;
        wait_sb(0, 200, 1'b0);
        repeat (2) tick();
        check_idle("restart_end", 1);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        cfg_enable = 1'b0;
        cfg_mode   = 2'd0;
        cfg_color  = 24'h0;
        tready     = 1'b1;
        test_reset();
        test_gradient();
        test_random_ready();
        test_mode_switch();
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
